dmem_arb: RTL and testbench
===========================

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 CLK  in  1  system clock; all state updates on rising edge.
REQ-002 RSTN  in  1  reset; asynchronous assert, active-low; deassertion synchronous to CLK.
REQ-003 M_REQ_N  in  1  MEM-stage request, active-low; held until M_STALL drops.
REQ-004 M_RW  in  1  MEM-stage direction: 1 = write, 0 = read.
REQ-005 M_ADDR / M_WDATA  in  32/32  MEM-stage address and write data.
REQ-006 M_RDATA  out  32  MEM-stage read data.
REQ-007 M_STALL  out  1  holds pipeline while MEM-stage access is pending.
REQ-008 D_REQ_N, D_RW, D_ADDR, D_WDATA  in  1/1/32/32  DMA/debug request, same encoding as the M_* request inputs.
REQ-009 D_RDATA  out  32 / D_ACK  out  1  DMA read data; completion pulse.
REQ-010 MEM_CSN, MEM_WEN  out  1/1  memory chip select and write enable, both active-low, registered.
REQ-011 MEM_ADDR, MEM_DI  out  32/32  memory address and write data, registered.
REQ-012 MEM_DO  in  32  synchronous-read memory data, valid the cycle after an access with MEM_CSN=0.

Function
REQ-013 FSM states: IDLE, MACC, MDONE, DACC, DDONE; reset state IDLE.
REQ-014 IDLE: M only requesting -> MACC; D only -> DACC; neither -> IDLE.
REQ-015 IDLE, both requesting: grant the requester not granted last; LAST_GNT register, reset value = D, so M wins the first conflict.
REQ-016 On IDLE->xACC edge: load MEM_CSN=0, MEM_WEN=~RW, MEM_ADDR, MEM_DI from the granted requester; LAST_GNT updated.
REQ-017 MACC->MDONE and DACC->DDONE unconditionally; on that edge MEM_CSN=1, MEM_WEN=1; address/data hold value.
REQ-018 MDONE->IDLE and DDONE->IDLE unconditionally; every access occupies exactly 3 cycles (IDLE, ACC, DONE).
REQ-019 M_STALL = RSTN & ~M_REQ_N & (state != MDONE), combinational; M request in IDLE stalls 2 cycles and releases in MDONE.
REQ-020 M_RDATA = MEM_DO while state == MDONE; else the value registered from MEM_DO at the end of the last MDONE.
REQ-021 D_ACK = 1 only in DDONE (single-cycle pulse); D_RDATA registered from MEM_DO on the DDONE->IDLE edge and held.
REQ-022 Writes follow the same timing; M_RDATA/D_RDATA update on write completion as well (value don't-care, still MEM_DO).
REQ-023 Request inputs sampled only in IDLE; requester dropping its request mid-access does not abort; access completes, result is discarded.
REQ-024 New requests arriving during xACC/xDONE wait until the next IDLE; no request is lost while held low.
REQ-025 Under continuous requests from both, grants alternate M, D, M, D; neither starves.

Reset
REQ-026 RSTN low: state=IDLE, LAST_GNT=D, MEM_CSN=1, MEM_WEN=1, MEM_ADDR=0, MEM_DI=0, M_RDATA=0, D_RDATA=0, D_ACK=0, M_STALL=0.
REQ-027 Reset mid-access abandons the access immediately; memory returns to idle (CSN=1, WEN=1) asynchronously.

Verification
REQ-028 M read 0x0000_0010, MEM_DO=0xDEAD_BEEF in MDONE -> M_STALL=1 for 2 cycles, MEM_CSN=0/MEM_WEN=1 in MACC, M_RDATA=0xDEAD_BEEF in MDONE and held.
REQ-029 D write 0x20 data 0x1234_5678 -> MEM_CSN=0, MEM_WEN=0, MEM_ADDR=0x20, MEM_DI=0x1234_5678 in DACC; D_ACK=1 for one cycle in DDONE.
REQ-030 M_REQ_N and D_REQ_N low simultaneously from reset, held -> grant order M, D, M, D; D_ACK every 6 cycles.
REQ-031 D access in DACC when M_REQ_N falls -> M_STALL=1 through DDONE, IDLE, MACC; released in MDONE (4 stall cycles).
REQ-032 RSTN pulsed low during MACC -> MEM_CSN=1, M_STALL=0 at once; after release, held M request restarts from IDLE with full 3-cycle access.

Source files
------------

// File: rtl/dmem_arb_if.sv
// dmem_arb_if
//   Bundles the two requester ports (MEM stage M_*, DMA/debug D_*) and the
//   synchronous-read memory port (MEM_*) of the data-memory arbiter.
//   slave  : arbiter side (takes requests, drives memory)
//   master : environment side (requesters and memory model)
interface dmem_arb_if;
    logic        M_REQ_N;
    logic        M_RW;
    logic [31:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [31:0] M_RDATA;
    logic        M_STALL;

    logic        D_REQ_N;
    logic        D_RW;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [31:0] D_RDATA;
    logic        D_ACK;

    logic        MEM_CSN;
    logic        MEM_WEN;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_DI;
    logic [31:0] MEM_DO;

    modport slave (
        input  M_REQ_N, M_RW, M_ADDR, M_WDATA,
        input  D_REQ_N, D_RW, D_ADDR, D_WDATA,
        input  MEM_DO,
        output M_RDATA, M_STALL, D_RDATA, D_ACK,
        output MEM_CSN, MEM_WEN, MEM_ADDR, MEM_DI
    );

    modport master (
        output M_REQ_N, M_RW, M_ADDR, M_WDATA,
        output D_REQ_N, D_RW, D_ADDR, D_WDATA,
        output MEM_DO,
        input  M_RDATA, M_STALL, D_RDATA, D_ACK,
        input  MEM_CSN, MEM_WEN, MEM_ADDR, MEM_DI
    );
endinterface

// File: rtl/dmem_arb.sv
// dmem_arb
//   Two-requester arbiter for a single-port synchronous-read data memory.
//   The MEM stage (M_*) and a DMA/debug port (D_*) share the memory; each
//   access takes exactly three cycles (IDLE, ACC, DONE). Conflicts in IDLE
//   are resolved round-robin so neither requester starves.
//
// Ports
//   CLK   : clock, all state on rising edge
//   RSTN  : asynchronous active-low reset
//   bus   : dmem_arb_if.slave -- requests in, stall/ack/read data out,
//           registered memory controls out, MEM_DO in
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | memory deselected; requests sampled and granted here
// MACC  | M access presented to memory (CSN=0)
// MDONE | M read data on MEM_DO; M_STALL released
// DACC  | D access presented to memory (CSN=0)
// DDONE | D read data on MEM_DO; D_ACK pulsed
module dmem_arb (
    input  logic       CLK,
    input  logic       RSTN,
    dmem_arb_if.slave  bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MACC  = 3'd1;
    localparam logic [2:0] MDONE = 3'd2;
    localparam logic [2:0] DACC  = 3'd3;
    localparam logic [2:0] DDONE = 3'd4;

    localparam logic GNT_M = 1'b0;
    localparam logic GNT_D = 1'b1;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        last_gnt;
    logic        m_req;
    logic        d_req;
    logic        grant_m;
    logic        grant_d;

    logic        mem_csn;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_di;
    logic [31:0] m_rdata_q;
    logic [31:0] d_rdata_q;

    assign m_req = ~bus.M_REQ_N;
    assign d_req = ~bus.D_REQ_N;

    // On a conflict, the requester that did not win last time gets the slot.
    always_comb begin
        grant_m = m_req & (~d_req | (last_gnt == GNT_D));
        grant_d = d_req & ~grant_m;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (grant_m)
                    state_nxt = MACC;
                else if (grant_d)
                    state_nxt = DACC;
                else
                    state_nxt = IDLE;
            end
            MACC:    state_nxt = MDONE;
            MDONE:   state_nxt = IDLE;
            DACC:    state_nxt = DDONE;
            DDONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            last_gnt  <= GNT_D;
            mem_csn   <= 1'b1;
            mem_wen   <= 1'b1;
            mem_addr  <= 32'd0;
            mem_di    <= 32'd0;
            m_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_m) begin
                        mem_csn  <= 1'b0;
                        mem_wen  <= ~bus.M_RW;
                        mem_addr <= bus.M_ADDR;
                        mem_di   <= bus.M_WDATA;
                        last_gnt <= GNT_M;
                    end else if (grant_d) begin
                        mem_csn  <= 1'b0;
                        mem_wen  <= ~bus.D_RW;
                        mem_addr <= bus.D_ADDR;
                        mem_di   <= bus.D_WDATA;
                        last_gnt <= GNT_D;
                    end
                end
                // Deselect after one access cycle; address/data simply hold.
                MACC, DACC: begin
                    mem_csn <= 1'b1;
                    mem_wen <= 1'b1;
                end
                // Capture read data as the DONE cycle ends (writes too; value
                // is meaningless then but keeps the path uniform).
                MDONE: m_rdata_q <= bus.MEM_DO;
                DDONE: d_rdata_q <= bus.MEM_DO;
                default: begin
                    mem_csn <= 1'b1;
                    mem_wen <= 1'b1;
                end
            endcase
        end
    end

    // Stall is gated by RSTN so it drops the instant reset is applied.
    assign bus.M_STALL  = RSTN & m_req & (state != MDONE);
    assign bus.M_RDATA  = (state == MDONE) ? bus.MEM_DO : m_rdata_q;
    assign bus.D_ACK    = (state == DDONE);
    assign bus.D_RDATA  = d_rdata_q;

    assign bus.MEM_CSN  = mem_csn;
    assign bus.MEM_WEN  = mem_wen;
    assign bus.MEM_ADDR = mem_addr;
    assign bus.MEM_DI   = mem_di;

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb
//   Directed bench for dmem_arb: reset values, M read, D write/read,
//   round-robin under continuous requests, M stall behind a D access,
//   request dropped mid-access, and reset during an access.
//   A small synchronous-read memory model drives MEM_DO.
module tb_dmem_arb;

    logic CLK;
    logic RSTN;
    int   checks;
    int   failures;

    logic [31:0] mem [0:63];

    dmem_arb_if bus ();

    dmem_arb u_dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read memory: data appears the cycle after CSN=0.
    // When deselected MEM_DO shows a marker so held values are really held.
    always @(posedge CLK) begin
        if (!bus.MEM_CSN) begin
            if (!bus.MEM_WEN)
                mem[bus.MEM_ADDR[7:2]] <= bus.MEM_DI;
            bus.MEM_DO <= mem[bus.MEM_ADDR[7:2]];
        end else begin
            bus.MEM_DO <= 32'hBADB_AD00;
        end
    end

    task automatic idle_inputs();
        bus.M_REQ_N = 1'b1; bus.M_RW = 1'b0; bus.M_ADDR = 32'd0; bus.M_WDATA = 32'd0;
        bus.D_REQ_N = 1'b1; bus.D_RW = 1'b0; bus.D_ADDR = 32'd0; bus.D_WDATA = 32'd0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        idle_inputs();
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.MEM_CSN !== 1'b1 || bus.MEM_WEN !== 1'b1) begin
            failures++; $display("FAIL reset_csn_wen got=%b%b exp=11", bus.MEM_CSN, bus.MEM_WEN);
        end
        checks++;
        if (bus.MEM_ADDR !== 32'd0 || bus.MEM_DI !== 32'd0) begin
            failures++; $display("FAIL reset_addr_di got=%h/%h exp=0/0", bus.MEM_ADDR, bus.MEM_DI);
        end
        checks++;
        if (bus.M_RDATA !== 32'd0 || bus.D_RDATA !== 32'd0) begin
            failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.M_RDATA, bus.D_RDATA);
        end
        checks++;
        if (bus.D_ACK !== 1'b0 || bus.M_STALL !== 1'b0) begin
            failures++; $display("FAIL reset_ack_stall got=%b%b exp=00", bus.D_ACK, bus.M_STALL);
        end
        RSTN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_m_read();
        int stalls = 0;
        bus.M_REQ_N = 1'b0; bus.M_RW = 1'b0; bus.M_ADDR = 32'h0000_0010;
        #1;
        if (bus.M_STALL === 1'b1) stalls++;
        @(negedge CLK); // MACC
        if (bus.M_STALL === 1'b1) stalls++;
        checks++;
        if (bus.MEM_CSN !== 1'b0 || bus.MEM_WEN !== 1'b1 || bus.MEM_ADDR !== 32'h10) begin
            failures++; $display("FAIL m_rd_macc got csn=%b wen=%b addr=%h exp 0 1 00000010",
                                 bus.MEM_CSN, bus.MEM_WEN, bus.MEM_ADDR);
        end
        @(negedge CLK); // MDONE
        if (bus.M_STALL === 1'b1) stalls++;
        checks++;
        if (bus.M_RDATA !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL m_rd_mdone_data got=%h exp=deadbeef", bus.M_RDATA);
        end
        checks++;
        if (bus.MEM_CSN !== 1'b1) begin
            failures++; $display("FAIL m_rd_mdone_csn got=%b exp=1", bus.MEM_CSN);
        end
        checks++;
        if (stalls != 2) begin
            failures++; $display("FAIL m_rd_stall_cycles got=%0d exp=2", stalls);
        end
        bus.M_REQ_N = 1'b1;
        @(negedge CLK); // IDLE
        @(negedge CLK);
        checks++;
        if (bus.M_RDATA !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL m_rd_held got=%h exp=deadbeef", bus.M_RDATA);
        end
    endtask

    task automatic test_d_write();
        bus.D_REQ_N = 1'b0; bus.D_RW = 1'b1; bus.D_ADDR = 32'h20; bus.D_WDATA = 32'h1234_5678;
        @(negedge CLK); // DACC
        checks++;
        if (bus.MEM_CSN !== 1'b0 || bus.MEM_WEN !== 1'b0 || bus.MEM_ADDR !== 32'h20 ||
            bus.MEM_DI !== 32'h1234_5678) begin
            failures++; $display("FAIL d_wr_dacc got csn=%b wen=%b addr=%h di=%h exp 0 0 00000020 12345678",
                                 bus.MEM_CSN, bus.MEM_WEN, bus.MEM_ADDR, bus.MEM_DI);
        end
        checks++;
        if (bus.D_ACK !== 1'b0) begin
            failures++; $display("FAIL d_wr_ack_early got=%b exp=0", bus.D_ACK);
        end
        @(negedge CLK); // DDONE
        checks++;
        if (bus.D_ACK !== 1'b1) begin
            failures++; $display("FAIL d_wr_ack got=%b exp=1", bus.D_ACK);
        end
        bus.D_REQ_N = 1'b1; bus.D_RW = 1'b0;
        @(negedge CLK); // IDLE
        checks++;
        if (bus.D_ACK !== 1'b0) begin
            failures++; $display("FAIL d_wr_ack_pulse got=%b exp=0", bus.D_ACK);
        end
        checks++;
        if (mem[8] !== 32'h1234_5678) begin
            failures++; $display("FAIL d_wr_mem got=%h exp=12345678", mem[8]);
        end
    endtask

    task automatic test_d_read();
        bus.D_REQ_N = 1'b0; bus.D_RW = 1'b0; bus.D_ADDR = 32'h30;
        @(negedge CLK); // DACC
        @(negedge CLK); // DDONE
        bus.D_REQ_N = 1'b1;
        @(negedge CLK); // IDLE
        @(negedge CLK);
        checks++;
        if (bus.D_RDATA !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL d_rd_data got=%h exp=cafef00d", bus.D_RDATA);
        end
        checks++;
        if (bus.M_RDATA !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL d_rd_m_untouched got=%h exp=deadbeef", bus.M_RDATA);
        end
    endtask

    // Both requesting continuously from reset: M, D, M, D with 6-cycle period.
    task automatic test_alternate();
        logic [31:0] exp_addr;
        int ph;
        RSTN = 1'b0;
        bus.M_REQ_N = 1'b0; bus.M_RW = 1'b0; bus.M_ADDR = 32'h10;
        bus.D_REQ_N = 1'b0; bus.D_RW = 1'b0; bus.D_ADDR = 32'h30;
        #1;
        checks++;
        if (bus.M_STALL !== 1'b0) begin
            failures++; $display("FAIL alt_stall_in_reset got=%b exp=0", bus.M_STALL);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            ph = (k - 1) % 6;
            exp_addr = (ph == 0) ? 32'h10 : 32'h30;
            checks++;
            if (bus.MEM_CSN !== ((ph == 0 || ph == 3) ? 1'b0 : 1'b1)) begin
                failures++; $display("FAIL alt_csn cyc=%0d got=%b", k, bus.MEM_CSN);
            end
            if (ph == 0 || ph == 3) begin
                checks++;
                if (bus.MEM_ADDR !== exp_addr) begin
                    failures++; $display("FAIL alt_grant cyc=%0d got=%h exp=%h", k, bus.MEM_ADDR, exp_addr);
                end
            end
            checks++;
            if (bus.D_ACK !== (ph == 4)) begin
                failures++; $display("FAIL alt_ack cyc=%0d got=%b exp=%b", k, bus.D_ACK, (ph == 4));
            end
            checks++;
            if (bus.M_STALL !== (ph != 1)) begin
                failures++; $display("FAIL alt_stall cyc=%0d got=%b exp=%b", k, bus.M_STALL, (ph != 1));
            end
        end
        idle_inputs();
        @(negedge CLK);
    endtask

    // M request arrives while D is in DACC: stalls DACC, DDONE, IDLE, MACC.
    task automatic test_stall_during_d();
        int stalls = 0;
        bus.D_REQ_N = 1'b0; bus.D_RW = 1'b0; bus.D_ADDR = 32'h30;
        @(negedge CLK); // DACC
        bus.D_REQ_N = 1'b1;
        bus.M_REQ_N = 1'b0; bus.M_RW = 1'b0; bus.M_ADDR = 32'h10;
        #1;
        if (bus.M_STALL === 1'b1) stalls++;
        @(negedge CLK); // DDONE
        if (bus.M_STALL === 1'b1) stalls++;
        checks++;
        if (bus.D_ACK !== 1'b1) begin
            failures++; $display("FAIL sd_ack got=%b exp=1", bus.D_ACK);
        end
        @(negedge CLK); // IDLE
        if (bus.M_STALL === 1'b1) stalls++;
        @(negedge CLK); // MACC
        if (bus.M_STALL === 1'b1) stalls++;
        checks++;
        if (bus.MEM_CSN !== 1'b0 || bus.MEM_ADDR !== 32'h10) begin
            failures++; $display("FAIL sd_macc got csn=%b addr=%h exp 0 00000010", bus.MEM_CSN, bus.MEM_ADDR);
        end
        @(negedge CLK); // MDONE
        if (bus.M_STALL === 1'b1) stalls++;
        checks++;
        if (stalls != 4) begin
            failures++; $display("FAIL sd_stall_cycles got=%0d exp=4", stalls);
        end
        checks++;
        if (bus.M_RDATA !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL sd_m_rdata got=%h exp=deadbeef", bus.M_RDATA);
        end
        bus.M_REQ_N = 1'b1;
        @(negedge CLK);
    endtask

    // M drops its request in MACC; the access still runs to MDONE, so the
    // D request raised at that moment is granted only after the next IDLE.
    task automatic test_drop_mid();
        bus.M_REQ_N = 1'b0; bus.M_RW = 1'b0; bus.M_ADDR = 32'h10;
        @(negedge CLK); // MACC
        bus.M_REQ_N = 1'b1;
        bus.D_REQ_N = 1'b0; bus.D_RW = 1'b0; bus.D_ADDR = 32'h30;
        @(negedge CLK); // MDONE
        @(negedge CLK); // IDLE
        checks++;
        if (bus.MEM_CSN !== 1'b1) begin
            failures++; $display("FAIL drop_no_abort got csn=%b exp=1", bus.MEM_CSN);
        end
        @(negedge CLK); // DACC
        checks++;
        if (bus.MEM_CSN !== 1'b0 || bus.MEM_ADDR !== 32'h30) begin
            failures++; $display("FAIL drop_d_grant got csn=%b addr=%h exp 0 00000030", bus.MEM_CSN, bus.MEM_ADDR);
        end
        bus.D_REQ_N = 1'b1;
        @(negedge CLK); // DDONE
        @(negedge CLK); // IDLE
    endtask

    // Reset during MACC abandons the access at once; held request restarts.
    task automatic test_reset_mid();
        int stalls = 0;
        bus.M_REQ_N = 1'b0; bus.M_RW = 1'b0; bus.M_ADDR = 32'h10;
        @(negedge CLK); // MACC
        #2;
        RSTN = 1'b0;
        #1;
        checks++;
        if (bus.MEM_CSN !== 1'b1 || bus.MEM_WEN !== 1'b1 || bus.M_STALL !== 1'b0) begin
            failures++; $display("FAIL rst_mid_async got csn=%b wen=%b stall=%b exp 1 1 0",
                                 bus.MEM_CSN, bus.MEM_WEN, bus.M_STALL);
        end
        checks++;
        if (bus.M_RDATA !== 32'd0 || bus.MEM_ADDR !== 32'd0) begin
            failures++; $display("FAIL rst_mid_clear got rdata=%h addr=%h exp 0 0", bus.M_RDATA, bus.MEM_ADDR);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
        if (bus.M_STALL === 1'b1) stalls++;
        @(negedge CLK); // MACC
        if (bus.M_STALL === 1'b1) stalls++;
        checks++;
        if (bus.MEM_CSN !== 1'b0 || bus.MEM_ADDR !== 32'h10) begin
            failures++; $display("FAIL rst_mid_restart got csn=%b addr=%h exp 0 00000010", bus.MEM_CSN, bus.MEM_ADDR);
        end
        @(negedge CLK); // MDONE
        if (bus.M_STALL === 1'b1) stalls++;
        checks++;
        if (stalls != 2 || bus.M_RDATA !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL rst_mid_complete got stalls=%0d rdata=%h exp 2 deadbeef", stalls, bus.M_RDATA);
        end
        bus.M_REQ_N = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4]  = 32'hDEAD_BEEF;
        mem[12] = 32'hCAFE_F00D;
        test_reset();
        test_m_read();
        test_d_write();
        test_d_read();
        test_alternate();
        test_stall_during_d();
        test_drop_mid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
